unidad_control_mc: RTL
======================

Name: unidad_control_mc

Overview:
- Parametrised multi-cycle control unit for the accumulator-style datapath: IR, two operand registers, ALU, I/O register, PC, shared memory.
- Sequences fetch/decode/execute/writeback/PC-update per instruction and drives all datapath enables and mux selects.
- Generalises the 2-bit, 4-op controller with:
  - wider opcode, adding AND, OR, conditional jump and halt
  - a memory-ready handshake with wait states
  - run/idle control and debug state visibility.

Parameters:
- OP_W, 3, opcode width; opcodes decoded from the low 3 bits, upper bits must be 0, otherwise treated as illegal.
- MUX_W, 2, width of selmux.
- ALU_W, 2, width of seloper.
- MEM_WAIT_EN, 1, 1: memory states stall until mem_ready=1; 0: mem_ready ignored, memory states last one cycle.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- run  in  1  start/continue execution
- opcode  in  OP_W  opcode field from IR output
- mem_ready  in  1  memory access complete this cycle
- zero_flag  in  1  ALU zero flag from last ALU result
- enmem  out  1  memory access enable
- wrmem  out  1  memory write (valid only with enmem)
- enir  out  1  IR load
- enrop1  out  1  operand-1 register load
- enrop2  out  1  operand-2 register load
- enrio  out  1  output register load
- enpc  out  1  PC increment
- ldpc  out  1  PC load from jump target
- seloper  out  ALU_W  ALU operation select
- selmux  out  MUX_W  memory address/data mux select
- halted  out  1  high while in HLT
- state_dbg  out  4  current state encoding

Behaviour:
- Synchronous active-low reset, one clock domain; on the clock edge with rst_n=0:
  - state goes to IDLE and op_q is cleared to 0
  - every output reads 0.
- Reset dominates every other input in any state, including wait states.
- Opcodes, latched into op_q on the cycle leaving D:
  - 000 SUM, 001 RES, 010 MOV, 011 OUT
  - 100 AND, 101 OR, 110 JZ, 111 HLT
  - any opcode with nonzero upper bits is illegal and goes to COU, treated as a NOP.
- States (4-bit codes): IDLE=0, F=1, D=2, OP1=3, OP2=4, WC=5, GA=6, WB=7, OA=8, JZ=9, COU=10, HLT=11.
- Unused codes go to IDLE on the next edge.
- Transitions:
  - IDLE: to F if run=1, else stay.
  - F: to D when memory done. Memory done means mem_ready=1, or is always true when MEM_WAIT_EN=0. Otherwise stay in F.
  - D:
    - SUM/RES/AND/OR: to OP1
    - MOV: to GA
    - OUT: to OA
    - JZ: to JZ
    - HLT: to HLT
    - illegal: to COU
  - OP1: to OP2. OP2: to WC. WC: to COU when memory done, else stay.
  - GA: to WB. WB: to COU when memory done, else stay. OA: to COU.
  - JZ: to F if zero_flag=1, else to COU.
  - COU: to F if run=1, else to IDLE.
  - HLT: stays until reset.
- Outputs are Moore, decoded from state; the only exception is ldpc. Any output not listed for a state is 0.
  - F: enmem=1, enir=1, selmux=0.
  - OP1: enrop1=1, selmux=1.
  - OP2: enrop2=1, selmux=2, seloper from op_q: SUM 0, RES 1, AND 2, OR 3.
  - WC: enmem=1, wrmem=1, selmux=3.
  - GA: enrop1=1, selmux=1.
  - WB: enmem=1, wrmem=1, selmux=2.
  - OA: enrio=1, selmux=1.
  - JZ: ldpc = zero_flag (Mealy).
  - COU: enpc=1.
  - HLT: halted=1.
  - state_dbg always equals the state code.
- Invariants:
  - enpc and ldpc are never high together.
  - wrmem is never high without enmem.
- Latency with no wait states, counted F through COU inclusive:
  - SUM/RES/AND/OR: 6 cycles
  - MOV: 5
  - OUT: 4
  - JZ taken: 3 (F, D, JZ), next F immediately
  - JZ not taken: 4
- Each mem_ready=0 cycle in F/WC/WB adds exactly one cycle; outputs are held constant during the wait.
- op_q holds from D until the next D. opcode changing after D has no effect.
- run is sampled only in IDLE and COU. Dropping run mid-instruction completes the instruction, then goes to IDLE.

Test Plan:
- Reset, then run=1, opcode=000 (SUM), mem_ready=1:
  - states 0,1,2,3,4,5,10,1
  - OP2 has seloper=0, selmux=2; WC has enmem=wrmem=1, selmux=3; enpc=1 for exactly one cycle.
- opcode=001 then 100 then 101, back-to-back with run=1 → seloper in OP2 = 1, 2, 3 respectively; no idle cycle between instructions.
- MOV with MEM_WAIT_EN=1 and mem_ready held 0 for 3 cycles in WB:
  - WB lasts 4 cycles with enmem=wrmem=1, selmux=2 stable
  - total MOV instruction takes 8 cycles.
- JZ:
  - zero_flag=1 → ldpc=1 for one cycle, enpc never asserted, next state F
  - zero_flag=0 → ldpc=0, COU asserts enpc=1.
- opcode=111 → halted=1, state_dbg=11 held for 20 cycles regardless of run/opcode; rst_n=0 for one edge → state_dbg=0, all outputs 0.
- Protocol edge cases:
  - rst_n=0 asserted during a WC wait (mem_ready=0) → next edge IDLE, enmem/wrmem drop to 0.
  - run=0 during OP1 → instruction completes, COU then IDLE (state 0), stays while run=0.

Source files
------------

// File: rtl/unidad_control_mc.sv
// Multi-cycle control unit for the accumulator datapath.
// Sequences each instruction through fetch, decode, execute, writeback and
// PC update, and drives every datapath enable and mux select.
// States (state_dbg code | meaning):
//    0 IDLE | waiting for run
//    1 F    | instruction fetch into IR, waits on mem_ready
//    2 D    | decode, opcode latched into op_q
//    3 OP1  | load operand 1
//    4 OP2  | load operand 2, ALU operation selected
//    5 WC   | write ALU result to memory, waits on mem_ready
//    6 GA   | MOV: load source operand
//    7 WB   | MOV: write to memory, waits on mem_ready
//    8 OA   | OUT: load output register
//    9 JZ   | conditional jump, ldpc follows zero_flag
//   10 COU  | PC increment, illegal opcodes land here as NOP
//   11 HLT  | halted until reset
module unidad_control_mc #(
    parameter int OP_W        = 3,
    parameter int MUX_W       = 2,
    parameter int ALU_W       = 2,
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [OP_W-1:0]  opcode,
    input  logic             mem_ready,
    input  logic             zero_flag,
    output logic             enmem,
    output logic             wrmem,
    output logic             enir,
    output logic             enrop1,
    output logic             enrop2,
    output logic             enrio,
    output logic             enpc,
    output logic             ldpc,
    output logic [ALU_W-1:0] seloper,
    output logic [MUX_W-1:0] selmux,
    output logic             halted,
    output logic [3:0]       state_dbg
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,  S_F   = 4'd1,  S_D   = 4'd2,  S_OP1 = 4'd3,
        S_OP2  = 4'd4,  S_WC  = 4'd5,  S_GA  = 4'd6,  S_WB  = 4'd7,
        S_OA   = 4'd8,  S_JZ  = 4'd9,  S_COU = 4'd10, S_HLT = 4'd11
    } state_t;

    state_t            state_q, state_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic              mem_done;
    logic              enmem_q, wrmem_q, enir_q, enrop1_q, enrop2_q, enrio_q, enpc_q, halted_q;
    logic [ALU_W-1:0]  seloper_q, seloper_d;
    logic [MUX_W-1:0]  selmux_q, selmux_d;

    // ALU select for the arithmetic/logic opcodes; anything else selects 0
    function automatic logic [ALU_W-1:0] alu_sel(input logic [OP_W-1:0] op);
        if ((op >> 3) != '0) return '0;
        case (op[2:0])
            3'b001:  return ALU_W'(2'd1);
            3'b100:  return ALU_W'(2'd2);
            3'b101:  return ALU_W'(2'd3);
            default: return '0;
        endcase
    endfunction

    // Next-state and opcode latch
    always_comb begin
        state_d  = S_IDLE;
        op_d     = op_q;
        mem_done = !MEM_WAIT_EN || mem_ready;
        case (state_q)
            S_IDLE: state_d = run ? S_F : S_IDLE;
            S_F:    state_d = mem_done ? S_D : S_F;
            S_D: begin
                op_d = opcode;
                if ((opcode >> 3) != '0) begin
                    state_d = S_COU;
                end else begin
                    case (opcode[2:0])
                        3'b010:  state_d = S_GA;
                        3'b011:  state_d = S_OA;
                        3'b110:  state_d = S_JZ;
                        3'b111:  state_d = S_HLT;
                        default: state_d = S_OP1;
                    endcase
                end
            end
            S_OP1:  state_d = S_OP2;
            S_OP2:  state_d = S_WC;
            S_WC:   state_d = mem_done ? S_COU : S_WC;
            S_GA:   state_d = S_WB;
            S_WB:   state_d = mem_done ? S_COU : S_WB;
            S_OA:   state_d = S_COU;
            S_JZ:   state_d = zero_flag ? S_F : S_COU;
            S_COU:  state_d = run ? S_F : S_IDLE;
            S_HLT:  state_d = S_HLT;
            default: state_d = S_IDLE;
        endcase
    end

    // Mux selects for the state being entered, so the registered copies match state_q
    always_comb begin
        seloper_d = (state_d == S_OP2) ? alu_sel(op_d) : '0;
        case (state_d)
            S_OP1, S_GA, S_OA: selmux_d = MUX_W'(2'd1);
            S_OP2, S_WB:       selmux_d = MUX_W'(2'd2);
            S_WC:              selmux_d = MUX_W'(2'd3);
            default:           selmux_d = '0;
        endcase
    end

    // State, opcode and registered Moore outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            enmem_q   <= 1'b0;
            wrmem_q   <= 1'b0;
            enir_q    <= 1'b0;
            enrop1_q  <= 1'b0;
            enrop2_q  <= 1'b0;
            enrio_q   <= 1'b0;
            enpc_q    <= 1'b0;
            halted_q  <= 1'b0;
            seloper_q <= '0;
            selmux_q  <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            enmem_q   <= (state_d == S_F) || (state_d == S_WC) || (state_d == S_WB);
            wrmem_q   <= (state_d == S_WC) || (state_d == S_WB);
            enir_q    <= (state_d == S_F);
            enrop1_q  <= (state_d == S_OP1) || (state_d == S_GA);
            enrop2_q  <= (state_d == S_OP2);
            enrio_q   <= (state_d == S_OA);
            enpc_q    <= (state_d == S_COU);
            halted_q  <= (state_d == S_HLT);
            seloper_q <= seloper_d;
            selmux_q  <= selmux_d;
        end
    end

    assign enmem     = enmem_q;
    assign wrmem     = wrmem_q;
    assign enir      = enir_q;
    assign enrop1    = enrop1_q;
    assign enrop2    = enrop2_q;
    assign enrio     = enrio_q;
    assign enpc      = enpc_q;
    assign halted    = halted_q;
    assign seloper   = seloper_q;
    assign selmux    = selmux_q;
    // Jump load is the one Mealy output: it follows zero_flag within the JZ cycle
    assign ldpc      = (state_q == S_JZ) && zero_flag;
    assign state_dbg = state_q;

endmodule
